// File: rtl/raster_tri_scheduler.sv
// Triangle sequencer between transform and rasterizer: fetches one triangle, sweeps the tile, then a readout sweep.
// Optional BBOX_SCAN_EN: restrict each triangle sweep to its clipped bounding box (adds a BOXC cycle).
module raster_tri_scheduler #(
    parameter int WIDTH  = 64,
    parameter int HEIGHT = 64,
    parameter int CW     = 9,
    localparam int HW    = $clog2(WIDTH),
    localparam int VW    = $clog2(HEIGHT)
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 start_in,
    input  logic                 tri_valid_in,
    input  logic                 tri_last_in,
    input  logic [2:0][CW-1:0]   v1_in,
    input  logic [2:0][CW-1:0]   v2_in,
    input  logic [2:0][CW-1:0]   v3_in,
    output logic                 tri_ready_out,
    output logic [2:0][CW-1:0]   vert1_out,
    output logic [2:0][CW-1:0]   vert2_out,
    output logic [2:0][CW-1:0]   vert3_out,
    output logic                 valid_tri_out,
    output logic                 obj_done_out,
    output logic                 new_frame_out,
    output logic [HW-1:0]        hcount_out,
    output logic [VW-1:0]        vcount_out,
    output logic                 busy_out,
    output logic                 frame_done_out
);

    localparam logic [HW-1:0] HMAX = HW'(WIDTH - 1);
    localparam logic [VW-1:0] VMAX = VW'(HEIGHT - 1);

    typedef enum logic [2:0] {
        IDLE, NEWF, FETCH, SCAN, FLUSH, DONE
`ifdef BBOX_SCAN_EN
        , BOXC
`endif
    } state_t;

    state_t state;
    logic   last_tri;
    logic   accept;

    assign accept = tri_valid_in && tri_ready_out;

`ifdef BBOX_SCAN_EN
    localparam logic [CW-1:0] XLIM = CW'(WIDTH - 1);
    localparam logic [CW-1:0] YLIM = CW'(HEIGHT - 1);

    logic [HW-1:0] x_lo, x_hi;
    logic [VW-1:0] y_lo, y_hi;
    logic [CW-1:0] bx_min, bx_max, by_min, by_max, bx_hi, by_hi;
    logic          box_off;

    function automatic logic [CW-1:0] min3(input logic [CW-1:0] a, b, c);
        logic [CW-1:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    function automatic logic [CW-1:0] max3(input logic [CW-1:0] a, b, c);
        logic [CW-1:0] m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Box is derived from the latched vertices during BOXC, so the source may change v*_in freely.
    always_comb begin
        bx_min  = min3(vert1_out[2], vert2_out[2], vert3_out[2]);
        bx_max  = max3(vert1_out[2], vert2_out[2], vert3_out[2]);
        by_min  = min3(vert1_out[1], vert2_out[1], vert3_out[1]);
        by_max  = max3(vert1_out[1], vert2_out[1], vert3_out[1]);
        bx_hi   = (bx_max > XLIM) ? XLIM : bx_max;
        by_hi   = (by_max > YLIM) ? YLIM : by_max;
        box_off = (bx_min > XLIM) || (by_min > YLIM);
    end
`else
    localparam logic [HW-1:0] x_lo = '0;
    localparam logic [HW-1:0] x_hi = HMAX;
    localparam logic [VW-1:0] y_lo = '0;
    localparam logic [VW-1:0] y_hi = VMAX;
`endif

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state          <= IDLE;
            last_tri       <= 1'b0;
            tri_ready_out  <= 1'b0;
            vert1_out      <= '0;
            vert2_out      <= '0;
            vert3_out      <= '0;
            valid_tri_out  <= 1'b0;
            obj_done_out   <= 1'b0;
            new_frame_out  <= 1'b0;
            hcount_out     <= '0;
            vcount_out     <= '0;
            busy_out       <= 1'b0;
            frame_done_out <= 1'b0;
`ifdef BBOX_SCAN_EN
            x_lo <= '0;
            x_hi <= '0;
            y_lo <= '0;
            y_hi <= '0;
`endif
        end else begin
            new_frame_out  <= 1'b0;
            frame_done_out <= 1'b0;
            case (state)
                IDLE: if (start_in) begin
                    state         <= NEWF;
                    new_frame_out <= 1'b1;
                    busy_out      <= 1'b1;
                end
                NEWF: begin
                    state         <= FETCH;
                    tri_ready_out <= 1'b1;
                end
                FETCH: if (accept) begin
                    vert1_out     <= v1_in;
                    vert2_out     <= v2_in;
                    vert3_out     <= v3_in;
                    last_tri      <= tri_last_in;
                    tri_ready_out <= 1'b0;
`ifdef BBOX_SCAN_EN
                    state         <= BOXC;
`else
                    hcount_out    <= x_lo;
                    vcount_out    <= y_lo;
                    valid_tri_out <= 1'b1;
                    state         <= SCAN;
`endif
                end
`ifdef BBOX_SCAN_EN
                BOXC: if (box_off) begin
                    // Nothing of this triangle lands on the tile: skip the sweep entirely.
                    if (last_tri) begin
                        state        <= FLUSH;
                        obj_done_out <= 1'b1;
                        hcount_out   <= '0;
                        vcount_out   <= '0;
                    end else begin
                        state         <= FETCH;
                        tri_ready_out <= 1'b1;
                    end
                end else begin
                    x_lo          <= bx_min[HW-1:0];
                    x_hi          <= bx_hi[HW-1:0];
                    y_lo          <= by_min[VW-1:0];
                    y_hi          <= by_hi[VW-1:0];
                    hcount_out    <= bx_min[HW-1:0];
                    vcount_out    <= by_min[VW-1:0];
                    valid_tri_out <= 1'b1;
                    state         <= SCAN;
                end
`endif
                SCAN: if (hcount_out == x_hi && vcount_out == y_hi) begin
                    valid_tri_out <= 1'b0;
                    if (last_tri) begin
                        state        <= FLUSH;
                        obj_done_out <= 1'b1;
                        hcount_out   <= '0;
                        vcount_out   <= '0;
                    end else begin
                        state         <= FETCH;
                        tri_ready_out <= 1'b1;
                    end
                end else if (hcount_out == x_hi) begin
                    hcount_out <= x_lo;
                    vcount_out <= vcount_out + 1'b1;
                end else begin
                    hcount_out <= hcount_out + 1'b1;
                end
                // Readout always covers the whole tile, independent of any bounding box.
                FLUSH: if (hcount_out == HMAX && vcount_out == VMAX) begin
                    obj_done_out   <= 1'b0;
                    frame_done_out <= 1'b1;
                    state          <= DONE;
                end else if (hcount_out == HMAX) begin
                    hcount_out <= '0;
                    vcount_out <= vcount_out + 1'b1;
                end else begin
                    hcount_out <= hcount_out + 1'b1;
                end
                DONE: begin
                    state    <= IDLE;
                    busy_out <= 1'b0;
                    last_tri <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_raster_tri_scheduler.sv
// Randomized self-checking bench for raster_tri_scheduler; scan extents come from a bounding-box model.
// Builds with or without BBOX_SCAN_EN; the model follows the same macro.
module tb_raster_tri_scheduler;

    localparam int W  = 64;
    localparam int H  = 64;
    localparam int CW = 9;
    localparam int HW = $clog2(W);
    localparam int VW = $clog2(H);
`ifdef BBOX_SCAN_EN
    localparam int BOXC_CYC = 1;
`else
    localparam int BOXC_CYC = 0;
`endif

    typedef logic [2:0][CW-1:0] vtx_t;
    typedef struct packed { vtx_t v1; vtx_t v2; vtx_t v3; } tri_t;

    logic          clk_in = 1'b0;
    logic          rst_in, start_in, tri_valid_in, tri_last_in;
    vtx_t          v1_in, v2_in, v3_in;
    logic          tri_ready_out, valid_tri_out, obj_done_out, new_frame_out;
    vtx_t          vert1_out, vert2_out, vert3_out;
    logic [HW-1:0] hcount_out;
    logic [VW-1:0] vcount_out;
    logic          busy_out, frame_done_out;

    raster_tri_scheduler #(.WIDTH(W), .HEIGHT(H), .CW(CW)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in),
        .tri_valid_in(tri_valid_in), .tri_last_in(tri_last_in),
        .v1_in(v1_in), .v2_in(v2_in), .v3_in(v3_in),
        .tri_ready_out(tri_ready_out),
        .vert1_out(vert1_out), .vert2_out(vert2_out), .vert3_out(vert3_out),
        .valid_tri_out(valid_tri_out), .obj_done_out(obj_done_out),
        .new_frame_out(new_frame_out), .hcount_out(hcount_out), .vcount_out(vcount_out),
        .busy_out(busy_out), .frame_done_out(frame_done_out)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int failures = 0;

    tri_t tris[8];
    int m_x0[8], m_y0[8], m_bw[8], m_area[8];
    int st_busy, st_newf, st_fd, st_acc, st_valid, st_obj, st_flush_entries;
    int st_order_err, st_vert_err, st_ready_bad, st_after_busy, st_timeout;
    int st_vper[8], st_fx[8], st_fy[8], st_lx[8], st_ly[8];

    function automatic vtx_t mkv(input int x, input int y, input int z);
        return {CW'(x), CW'(y), CW'(z)};
    endfunction

    // Reference: which pixels a triangle should visit, in raster order within its box.
    function automatic void model_box(input tri_t t, output int x0, output int y0,
                                      output int bw, output int area);
`ifdef BBOX_SCAN_EN
        int xa, xb, xc, ya, yb, yc, xmn, xmx, ymn, ymx;
        xa = int'(t.v1[2]); xb = int'(t.v2[2]); xc = int'(t.v3[2]);
        ya = int'(t.v1[1]); yb = int'(t.v2[1]); yc = int'(t.v3[1]);
        xmn = (xa < xb ? xa : xb); xmn = (xmn < xc ? xmn : xc);
        xmx = (xa > xb ? xa : xb); xmx = (xmx > xc ? xmx : xc);
        ymn = (ya < yb ? ya : yb); ymn = (ymn < yc ? ymn : yc);
        ymx = (ya > yb ? ya : yb); ymx = (ymx > yc ? ymx : yc);
        if (xmx > W - 1) xmx = W - 1;
        if (ymx > H - 1) ymx = H - 1;
        if (xmn > W - 1 || ymn > H - 1) begin
            x0 = 0; y0 = 0; bw = 1; area = 0;
        end else begin
            x0 = xmn; y0 = ymn; bw = xmx - xmn + 1; area = bw * (ymx - ymn + 1);
        end
`else
        x0 = 0; y0 = 0; bw = W; area = W * H;
`endif
    endfunction

    function automatic int exp_busy(input int n);
        int s;
        s = 2 + W * H;
        for (int i = 0; i < n; i++) s += 1 + BOXC_CYC + m_area[i];
        return s;
    endfunction

    task automatic present(input int k, input int n);
        tri_valid_in = 1'b1;
        v1_in = tris[k].v1; v2_in = tris[k].v2; v3_in = tris[k].v3;
        tri_last_in = (k == n - 1);
    endtask

    // Drives one frame of n triangles and gathers observations; comparisons live in the test tasks.
    task automatic run_frame(input int n, input int gap, input bit poke);
        int k, gapc, cur, pix, fpix, cyc, post, ex, ey;
        bit adv, acc, prev_ready, prev_acc, prev_obj, done_seen;
        st_busy = 0; st_newf = 0; st_fd = 0; st_acc = 0; st_valid = 0; st_obj = 0;
        st_flush_entries = 0; st_order_err = 0; st_vert_err = 0; st_ready_bad = 0;
        st_after_busy = 0; st_timeout = 0;
        for (int i = 0; i < 8; i++) begin
            st_vper[i] = 0; st_fx[i] = -1; st_fy[i] = -1; st_lx[i] = -1; st_ly[i] = -1;
        end
        for (int i = 0; i < n; i++) model_box(tris[i], m_x0[i], m_y0[i], m_bw[i], m_area[i]);
        k = 0; cur = -1; pix = 0; fpix = 0; cyc = 0; post = 0;
        adv = 0; prev_ready = 0; prev_acc = 0; prev_obj = 0; done_seen = 0;
        @(negedge clk_in);
        start_in = 1'b1;
        if (gap == 0) begin present(0, n); gapc = 0; end
        else begin tri_valid_in = 1'b0; gapc = gap; end
        forever begin
            @(negedge clk_in);
            cyc++;
            if (busy_out) st_busy++;
            if (new_frame_out) st_newf++;
            if (frame_done_out) st_fd++;
            if (tri_ready_out && (valid_tri_out || obj_done_out)) st_ready_bad++;
            if (prev_ready && !prev_acc && !tri_ready_out) st_ready_bad++;
            if (valid_tri_out) begin
                st_valid++;
                if (cur < 0 || obj_done_out) st_order_err++;
                else begin
                    st_vper[cur]++;
                    ex = m_x0[cur] + pix % m_bw[cur];
                    ey = m_y0[cur] + pix / m_bw[cur];
                    if (pix == 0) begin st_fx[cur] = int'(hcount_out); st_fy[cur] = int'(vcount_out); end
                    st_lx[cur] = int'(hcount_out); st_ly[cur] = int'(vcount_out);
                    if (int'(hcount_out) != ex || int'(vcount_out) != ey) st_order_err++;
                    if (vert1_out !== tris[cur].v1 || vert2_out !== tris[cur].v2 ||
                        vert3_out !== tris[cur].v3) st_vert_err++;
                    pix++;
                end
            end
            if (obj_done_out) begin
                st_obj++;
                if (!prev_obj) st_flush_entries++;
                if (int'(hcount_out) != fpix % W || int'(vcount_out) != fpix / W) st_order_err++;
                fpix++;
            end
            prev_obj = obj_done_out;
            if (poke && ((valid_tri_out && st_valid == 100) || (obj_done_out && st_obj == 100)))
                start_in = 1'b1;
            else
                start_in = 1'b0;
            if (adv) begin
                adv = 0;
                k++;
                if (k < n && gap == 0) present(k, n);
                else begin tri_valid_in = 1'b0; gapc = (k < n) ? gap : 0; end
            end else if (gapc > 0) begin
                gapc--;
                if (gapc == 0) present(k, n);
            end
            acc = tri_valid_in && tri_ready_out;
            if (acc) begin st_acc++; cur = k; pix = 0; adv = 1; end
            prev_ready = tri_ready_out;
            prev_acc = acc;
            if (done_seen) begin
                post++;
                if (busy_out) st_after_busy++;
                if (post >= 6) break;
            end
            if (frame_done_out) done_seen = 1;
            if (cyc > 30000) begin st_timeout = 1; break; end
        end
        tri_valid_in = 1'b0;
        start_in = 1'b0;
    endtask

    task automatic test_reset;
        int waited, fd, bz;
        rst_in = 1'b1; start_in = 1'b0; tri_valid_in = 1'b0; tri_last_in = 1'b0;
        v1_in = '0; v2_in = '0; v3_in = '0;
        #2;
        checks++;
        if ({tri_ready_out, valid_tri_out, obj_done_out, new_frame_out, busy_out, frame_done_out,
             hcount_out, vcount_out, vert1_out, vert2_out, vert3_out} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got ready=%b valid=%b obj=%b busy=%b h=%0d v=%0d exp all zero",
                     tri_ready_out, valid_tri_out, obj_done_out, busy_out, hcount_out, vcount_out);
        end
        repeat (3) @(negedge clk_in);
        rst_in = 1'b0;
        repeat (3) @(negedge clk_in);
        checks++;
        if (busy_out !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", busy_out); end
        tris[0] = '{mkv(20, 20, 3), mkv(20, 40, 4), mkv(40, 20, 5)};
        start_in = 1'b1;
        present(0, 1);
        waited = 0;
        @(negedge clk_in);
        start_in = 1'b0;
        while (!valid_tri_out && waited < 30) begin @(negedge clk_in); waited++; end
        checks++;
        if (valid_tri_out !== 1'b1) begin failures++; $display("FAIL reset_scan_reach got=%b exp=1", valid_tri_out); end
        repeat (10) @(negedge clk_in);
        #2 rst_in = 1'b1;
        #1;
        checks++;
        if ({tri_ready_out, valid_tri_out, obj_done_out, new_frame_out, busy_out, frame_done_out,
             hcount_out, vcount_out, vert1_out, vert2_out, vert3_out} !== '0) begin
            failures++;
            $display("FAIL reset_async got valid=%b busy=%b h=%0d v=%0d v1=%h exp all zero",
                     valid_tri_out, busy_out, hcount_out, vcount_out, vert1_out);
        end
        tri_valid_in = 1'b0;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
        fd = 0; bz = 0;
        repeat (20) begin
            @(negedge clk_in);
            if (frame_done_out) fd++;
            if (busy_out) bz++;
        end
        checks++;
        if (fd !== 0) begin failures++; $display("FAIL reset_no_frame_done got=%0d exp=0", fd); end
        checks++;
        if (bz !== 0) begin failures++; $display("FAIL reset_idle_busy got=%0d exp=0", bz); end
    endtask

    task automatic test_single_tri;
        tris[0] = '{mkv(20, 20, 7), mkv(20, 40, 8), mkv(40, 20, 9)};
        run_frame(1, 0, 0);
        checks++;
        if (st_timeout !== 0) begin failures++; $display("FAIL single_timeout got=%0d exp=0", st_timeout); end
        checks++;
        if (st_newf !== 1) begin failures++; $display("FAIL single_new_frame got=%0d exp=1", st_newf); end
        checks++;
        if (st_acc !== 1) begin failures++; $display("FAIL single_accepts got=%0d exp=1", st_acc); end
        checks++;
        if (st_valid !== m_area[0]) begin failures++; $display("FAIL single_valid_cycles got=%0d exp=%0d", st_valid, m_area[0]); end
        checks++;
        if (st_fx[0] !== m_x0[0] || st_fy[0] !== m_y0[0]) begin
            failures++; $display("FAIL single_first_px got=(%0d,%0d) exp=(%0d,%0d)", st_fx[0], st_fy[0], m_x0[0], m_y0[0]);
        end
        checks++;
        if (st_lx[0] !== m_x0[0] + m_bw[0] - 1 || st_ly[0] !== m_y0[0] + m_area[0] / m_bw[0] - 1) begin
            failures++; $display("FAIL single_last_px got=(%0d,%0d) exp=(%0d,%0d)", st_lx[0], st_ly[0],
                                 m_x0[0] + m_bw[0] - 1, m_y0[0] + m_area[0] / m_bw[0] - 1);
        end
        checks++;
        if (st_obj !== W * H || st_flush_entries !== 1) begin
            failures++; $display("FAIL single_flush got=%0d/%0d exp=%0d/1", st_obj, st_flush_entries, W * H);
        end
        checks++;
        if (st_fd !== 1) begin failures++; $display("FAIL single_frame_done got=%0d exp=1", st_fd); end
        checks++;
        if (st_busy !== exp_busy(1)) begin failures++; $display("FAIL single_total_cycles got=%0d exp=%0d", st_busy, exp_busy(1)); end
        checks++;
        if (st_order_err !== 0 || st_vert_err !== 0 || st_ready_bad !== 0 || st_after_busy !== 0) begin
            failures++; $display("FAIL single_protocol got order=%0d vert=%0d ready=%0d after=%0d exp all 0",
                                 st_order_err, st_vert_err, st_ready_bad, st_after_busy);
        end
    endtask

    task automatic test_multi_tri;
        int sum;
        for (int i = 0; i < 3; i++)
            tris[i] = '{mkv($urandom_range(80, 0), $urandom_range(80, 0), $urandom_range(511, 0)),
                        mkv($urandom_range(80, 0), $urandom_range(80, 0), $urandom_range(511, 0)),
                        mkv($urandom_range(80, 0), $urandom_range(80, 0), $urandom_range(511, 0))};
        run_frame(3, 5, 0);
        sum = m_area[0] + m_area[1] + m_area[2];
        checks++;
        if (st_timeout !== 0 || st_acc !== 3) begin failures++; $display("FAIL multi_accepts got=%0d exp=3", st_acc); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (st_vper[i] !== m_area[i]) begin
                failures++; $display("FAIL multi_valid_tri%0d got=%0d exp=%0d", i, st_vper[i], m_area[i]);
            end
        end
        checks++;
        if (st_valid !== sum) begin failures++; $display("FAIL multi_valid_total got=%0d exp=%0d", st_valid, sum); end
        checks++;
        if (st_flush_entries !== 1 || st_obj !== W * H) begin
            failures++; $display("FAIL multi_flush got=%0d/%0d exp=1/%0d", st_flush_entries, st_obj, W * H);
        end
        checks++;
        if (st_vert_err !== 0) begin failures++; $display("FAIL multi_vert_stable got=%0d exp=0", st_vert_err); end
        checks++;
        if (st_ready_bad !== 0) begin failures++; $display("FAIL multi_ready got=%0d exp=0", st_ready_bad); end
        checks++;
        if (st_order_err !== 0 || st_fd !== 1) begin
            failures++; $display("FAIL multi_order_done got order=%0d fd=%0d exp=0/1", st_order_err, st_fd);
        end
    endtask

    task automatic test_offtile;
        tris[0] = '{mkv(100, $urandom_range(63, 0), 1), mkv(100, $urandom_range(63, 0), 2),
                    mkv(100, $urandom_range(63, 0), 3)};
        run_frame(1, 0, 0);
        checks++;
        if (st_valid !== m_area[0]) begin failures++; $display("FAIL offtile_valid got=%0d exp=%0d", st_valid, m_area[0]); end
        checks++;
        if (st_busy !== exp_busy(1) || st_fd !== 1 || st_acc !== 1) begin
            failures++; $display("FAIL offtile_frame got busy=%0d fd=%0d acc=%0d exp=%0d/1/1", st_busy, st_fd, st_acc, exp_busy(1));
        end
    endtask

    task automatic test_start_ignored;
        tris[0] = '{mkv(10, 5, 0), mkv(30, 12, 0), mkv(15, 25, 0)};
        run_frame(1, 0, 1);
        checks++;
        if (st_fd !== 1 || st_newf !== 1) begin
            failures++; $display("FAIL start_ignored got fd=%0d newf=%0d exp=1/1", st_fd, st_newf);
        end
        checks++;
        if (st_after_busy !== 0 || st_busy !== exp_busy(1)) begin
            failures++; $display("FAIL start_no_restart got after=%0d busy=%0d exp=0/%0d", st_after_busy, st_busy, exp_busy(1));
        end
        run_frame(1, 0, 0);
        checks++;
        if (st_fd !== 1 || st_valid !== m_area[0] || st_timeout !== 0) begin
            failures++; $display("FAIL start_next_frame got fd=%0d valid=%0d exp=1/%0d", st_fd, st_valid, m_area[0]);
        end
    endtask

    initial begin
        test_reset();
        test_single_tri();
        test_multi_tri();
        test_offtile();
        test_start_ignored();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
